pixel_axi_burst_writer: RTL and testbench
=========================================

Name: pixel_axi_burst_writer

Overview:
Drains the processed-pixel FIFO into the frame buffer over the AXI4 pixel-transfer master (s_aw*/s_w*/s_b*).
- Issues fixed-length INCR bursts.
- Generates frame-buffer addresses from a configured base and frame size.
- Checks write responses and reports frame completion and errors to the configuration block.
- Sits between pixel_downscaler_fifo and the AXI interconnect, in the system clock domain.

Parameters:
DATA_W, 32, AXI data width (bytes per beat = DATA_W/8)
ADDR_W, 32, AXI address width
MST_ID_W, 5, AXI ID width
TRANS_DATA_LEN_W, 8, AWLEN width
TRANS_DATA_SIZE_W, 3, AWSIZE width
TRANS_RESP_W, 2, BRESP width
BURST_LEN, 16, beats per burst (power of two, 2..256)
FIFO_CNT_W, 6, width of FIFO occupancy input
FRAME_W, 20, width of frame size in words
AXI_ID, 0, constant AWID value

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
en_i  in  1  capture enable from config block
base_addr_i  in  ADDR_W  frame-buffer base (byte address, burst-aligned)
frame_words_i  in  FRAME_W  words per frame (multiple of BURST_LEN, nonzero)
frame_start_i  in  1  one-cycle pulse at start of frame (VSYNC-derived)
err_clr_i  in  1  clears err_o
fifo_data_i  in  DATA_W  FIFO head word (first-word-fall-through)
fifo_cnt_i  in  FIFO_CNT_W  FIFO occupancy in words
fifo_rd_o  out  1  FIFO pop
s_awid_o  out  MST_ID_W  =AXI_ID
s_awaddr_o  out  ADDR_W  burst address
s_awlen_o  out  TRANS_DATA_LEN_W  =BURST_LEN-1
s_awsize_o  out  TRANS_DATA_SIZE_W  =log2(DATA_W/8)
s_awvalid_o  out  1  address valid
s_awready_i  in  1  address ready
s_wdata_o  out  DATA_W  =fifo_data_i
s_wlast_o  out  1  last beat
s_wvalid_o  out  1  data valid
s_wready_i  in  1  data ready
s_bid_i  in  MST_ID_W  response ID
s_bresp_i  in  TRANS_RESP_W  response
s_bvalid_i  in  1  response valid
s_bready_o  out  1  response ready
busy_o  out  1  frame in progress
frame_done_o  out  1  one-cycle pulse when last burst of a frame is acknowledged
frame_drop_o  out  1  one-cycle pulse when frame_start_i is ignored
err_o  out  1  sticky: bresp!=OKAY or bid!=AXI_ID

Behaviour:
- Reset values:
  - Every valid/ready/pulse output is 0; err_o=0; busy_o=0.
  - Address and beat counters are 0; state is IDLE.
  - Constant outputs (awid, awlen, awsize) are driven regardless of reset.
- Only one burst is outstanding at a time.
- States:
  - IDLE:
    - If frame_start_i & en_i: latch base_addr_i into addr, load remaining bursts = frame_words_i/BURST_LEN, set busy_o, go to WAIT_DATA.
    - If frame_start_i & !en_i: ignore the pulse (frame_drop_o stays 0).
  - WAIT_DATA:
    - If fifo_cnt_i >= BURST_LEN: go to ADDR.
    - Else, if !en_i: go to IDLE, clear busy_o.
  - ADDR:
    - Hold s_awvalid_o=1 with a stable address until s_awready_i, then go to DATA with beat=0.
  - DATA:
    - s_wvalid_o=1.
    - fifo_rd_o = s_wvalid_o & s_wready_i (combinational).
    - s_wlast_o = (beat==BURST_LEN-1).
    - Each handshake increments beat; the handshake with wlast goes to RESP.
  - RESP:
    - s_bready_o=1.
    - On s_bvalid_i: set err_o if the response is bad, addr += BURST_LEN*DATA_W/8, remaining -= 1.
    - If remaining hits 0: pulse frame_done_o, clear busy_o, go to IDLE.
    - Else if !en_i: go to IDLE, clear busy_o (no done pulse).
    - Else go to WAIT_DATA.
- Latency: the AW request is asserted the cycle after the WAIT_DATA condition is met. W beats may issue back-to-back, one per cycle.
- frame_start_i in any state other than IDLE: pulse frame_drop_o the same cycle; the current frame continues unchanged.
- en_i deasserted mid-burst: the burst always completes (AW, all W beats, B). The stop takes effect only at the WAIT_DATA/RESP decision points.
- err_o: set on a bad response, cleared by err_clr_i. Set wins over clear in the same cycle.
- Address arithmetic is modulo 2^ADDR_W. No 4 KB-boundary check; base alignment to the burst size is the software's responsibility.
- rst_i mid-burst: abandon immediately and return to reset values. The interconnect is reset by the same rst_i.
- Config inputs (base_addr_i, frame_words_i) are sampled only at frame start.

Decomposition:
- Shared package dvp_rx_pkg holds:
  - AXI response constants (RESP_OKAY=2'b00).
  - The state enum localparams.
  - The awsize computation function.
- No sub-module: a single FSM with address/beat/remaining counters.

Test Plan:
1. BURST_LEN=16, frame_words=64, base=0x8000_0000, fifo_cnt held at 32, all readies=1 → 4 AW at 0x8000_0000/40/80/C0, each awlen=15, awsize=2; 64 fifo_rd pulses; wlast on beats 15/31/47/63; one frame_done_o after the 4th B.
2. fifo_cnt=15 for 50 cycles, then 16 → no AW until fifo_cnt=16; AW on the next cycle.
3. s_wready_i toggling randomly, s_awready_i delayed 5 cycles → awaddr stable while awvalid is high; wdata equals the FIFO sequence; exactly 16 pops per burst.
4. bresp=2'b10 on burst 2 → err_o=1 and stays 1, frame still completes; err_clr_i → err_o=0 the next cycle.
5. frame_start_i during burst 1 → frame_drop_o pulse; addresses unchanged. en_i=0 mid-burst 2 → burst 2 completes, then IDLE, busy_o=0, no frame_done_o.
6. rst_i asserted mid-DATA → the next cycle has all valids=0, fifo_rd_o=0, busy_o=0, err_o=0; a new frame_start_i restarts at base.

Source files
------------

// File: rtl/dvp_rx_pkg.sv
// Shared definitions for the pixel capture path: AXI response codes, the
// burst-writer state encoding and the AWSIZE helper.
package dvp_rx_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_ADDR      = 3'd2,
    ST_DATA      = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  // AWSIZE encoding is log2 of the bytes per beat; DATA_W must be 8..1024.
  function automatic logic [2:0] calc_awsize(input int unsigned data_w);
    logic [2:0] size_v;
    size_v = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd8 << i) == data_w) begin
        size_v = 3'(i);
      end else begin
        size_v = size_v;
      end
    end
    return size_v;
  endfunction

endpackage

// File: rtl/pixel_axi_burst_writer.sv
// Drains the processed-pixel FIFO into the frame buffer as fixed-length AXI4
// INCR write bursts, one burst outstanding at a time.
module pixel_axi_burst_writer
  import dvp_rx_pkg::*;
#(
  parameter int DATA_W            = 32,
  parameter int ADDR_W            = 32,
  parameter int MST_ID_W          = 5,
  parameter int TRANS_DATA_LEN_W  = 8,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int TRANS_RESP_W      = 2,
  parameter int BURST_LEN         = 16,
  parameter int FIFO_CNT_W        = 6,
  parameter int FRAME_W           = 20,
  parameter int AXI_ID            = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic [ADDR_W-1:0]            base_addr_i,
  input  logic [FRAME_W-1:0]           frame_words_i,
  input  logic                         frame_start_i,
  input  logic                         err_clr_i,
  input  logic [DATA_W-1:0]            fifo_data_i,
  input  logic [FIFO_CNT_W-1:0]        fifo_cnt_i,
  output logic                         fifo_rd_o,
  output logic [MST_ID_W-1:0]          s_awid_o,
  output logic [ADDR_W-1:0]            s_awaddr_o,
  output logic [TRANS_DATA_LEN_W-1:0]  s_awlen_o,
  output logic [TRANS_DATA_SIZE_W-1:0] s_awsize_o,
  output logic                         s_awvalid_o,
  input  logic                         s_awready_i,
  output logic [DATA_W-1:0]            s_wdata_o,
  output logic                         s_wlast_o,
  output logic                         s_wvalid_o,
  input  logic                         s_wready_i,
  input  logic [MST_ID_W-1:0]          s_bid_i,
  input  logic [TRANS_RESP_W-1:0]      s_bresp_i,
  input  logic                         s_bvalid_i,
  output logic                         s_bready_o,
  output logic                         busy_o,
  output logic                         frame_done_o,
  output logic                         frame_drop_o,
  output logic                         err_o
);

  localparam int BURST_SHIFT = $clog2(BURST_LEN);
  localparam int BEAT_W      = (BURST_SHIFT > 0) ? BURST_SHIFT : 1;

  localparam logic [ADDR_W-1:0]  BURST_BYTES = ADDR_W'(BURST_LEN * (DATA_W / 8));
  localparam logic [BEAT_W-1:0]  LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0]  BEAT_ONE    = BEAT_W'(1);
  localparam logic [BEAT_W-1:0]  BEAT_ZERO   = {BEAT_W{1'b0}};
  localparam logic [FRAME_W-1:0] ONE_BURST   = FRAME_W'(1);
  localparam logic [31:0]        BURST_LEN_U = 32'(BURST_LEN);

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [BEAT_W-1:0]   beat_r, beat_s;
  logic [FRAME_W-1:0]  remaining_r, remaining_s;
  logic                err_r, err_s;
  logic                done_r, done_s;

  logic                fifo_ready_s;
  logic                b_hs_s;
  logic                bad_resp_s;

  assign fifo_ready_s = (32'(fifo_cnt_i) >= BURST_LEN_U);
  assign b_hs_s       = (state_r == ST_RESP) && s_bvalid_i;
  assign bad_resp_s   = (s_bresp_i != TRANS_RESP_W'(RESP_OKAY)) ||
                        (s_bid_i != MST_ID_W'(AXI_ID));

  // Next-state, counter and sticky-error logic.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    beat_s      = beat_r;
    remaining_s = remaining_r;
    done_s      = 1'b0;

    // A new bad response outranks a same-cycle clear.
    if (b_hs_s && bad_resp_s) begin
      err_s = 1'b1;
    end else if (err_clr_i) begin
      err_s = 1'b0;
    end else begin
      err_s = err_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (frame_start_i && en_i) begin
          addr_s      = base_addr_i;
          remaining_s = frame_words_i >> BURST_SHIFT;
          beat_s      = BEAT_ZERO;
          state_s     = ST_WAIT_DATA;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WAIT_DATA: begin
        if (fifo_ready_s) begin
          beat_s  = BEAT_ZERO;
          state_s = ST_ADDR;
        end else if (!en_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_DATA;
        end
      end

      ST_ADDR: begin
        if (s_awready_i) begin
          beat_s  = BEAT_ZERO;
          state_s = ST_DATA;
        end else begin
          state_s = ST_ADDR;
        end
      end

      ST_DATA: begin
        if (s_wready_i) begin
          if (beat_r == LAST_BEAT) begin
            beat_s  = BEAT_ZERO;
            state_s = ST_RESP;
          end else begin
            beat_s  = beat_r + BEAT_ONE;
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end

      ST_RESP: begin
        if (s_bvalid_i) begin
          addr_s      = addr_r + BURST_BYTES;
          remaining_s = remaining_r - ONE_BURST;
          if (remaining_r == ONE_BURST) begin
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else if (!en_i) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_WAIT_DATA;
          end
        end else begin
          state_s = ST_RESP;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      beat_r      <= BEAT_ZERO;
      remaining_r <= {FRAME_W{1'b0}};
      err_r       <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      beat_r      <= beat_s;
      remaining_r <= remaining_s;
      err_r       <= err_s;
      done_r      <= done_s;
    end
  end

  assign s_awid_o     = MST_ID_W'(AXI_ID);
  assign s_awlen_o    = TRANS_DATA_LEN_W'(BURST_LEN - 1);
  assign s_awsize_o   = TRANS_DATA_SIZE_W'(calc_awsize(DATA_W));
  assign s_awaddr_o   = addr_r;
  assign s_awvalid_o  = (state_r == ST_ADDR);

  // Write data is the FIFO head directly; the pop is the W handshake itself.
  assign s_wdata_o    = fifo_data_i;
  assign s_wvalid_o   = (state_r == ST_DATA);
  assign s_wlast_o    = (state_r == ST_DATA) && (beat_r == LAST_BEAT);
  assign fifo_rd_o    = s_wvalid_o && s_wready_i;

  assign s_bready_o   = (state_r == ST_RESP);

  assign busy_o       = (state_r != ST_IDLE);
  assign frame_done_o = done_r;
  assign frame_drop_o = frame_start_i && (state_r != ST_IDLE);
  assign err_o        = err_r;

endmodule

// File: tb/tb_pixel_axi_burst_writer.sv
// Directed self-checking bench for pixel_axi_burst_writer with a FIFO model,
// an AXI slave responder and a handshake monitor.
module tb_pixel_axi_burst_writer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b1;
  logic [31:0] base_addr_i = 32'h0;
  logic [19:0] frame_words_i = 20'd0;
  logic        frame_start_i = 1'b0;
  logic        err_clr_i = 1'b0;
  logic [31:0] fifo_data_i;
  logic [5:0]  fifo_cnt_i = 6'd32;
  logic        fifo_rd_o;
  logic [4:0]  s_awid_o;
  logic [31:0] s_awaddr_o;
  logic [7:0]  s_awlen_o;
  logic [2:0]  s_awsize_o;
  logic        s_awvalid_o;
  logic        s_awready_i = 1'b0;
  logic [31:0] s_wdata_o;
  logic        s_wlast_o;
  logic        s_wvalid_o;
  logic        s_wready_i = 1'b1;
  logic [4:0]  s_bid_i = 5'd0;
  logic [1:0]  s_bresp_i = 2'b00;
  logic        s_bvalid_i = 1'b0;
  logic        s_bready_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        frame_drop_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  // Responder configuration
  int aw_delay = 0;
  bit wready_rand = 1'b0;
  int bad_b_at = -1;

  // Monitor statistics
  logic [31:0] aw_q[$];
  int          wlast_q[$];
  int          beats, b_count, done_cnt, drop_cnt;
  int          aw_valid_cycles, stab_err, attr_err, rd_err, wdata_err;
  logic [31:0] w_exp;
  logic [31:0] aw_hold_addr;
  bit          aw_hold_valid;

  logic [31:0] fifo_head = 32'h1000_0000;

  pixel_axi_burst_writer dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .base_addr_i(base_addr_i),
    .frame_words_i(frame_words_i), .frame_start_i(frame_start_i),
    .err_clr_i(err_clr_i), .fifo_data_i(fifo_data_i), .fifo_cnt_i(fifo_cnt_i),
    .fifo_rd_o(fifo_rd_o), .s_awid_o(s_awid_o), .s_awaddr_o(s_awaddr_o),
    .s_awlen_o(s_awlen_o), .s_awsize_o(s_awsize_o), .s_awvalid_o(s_awvalid_o),
    .s_awready_i(s_awready_i), .s_wdata_o(s_wdata_o), .s_wlast_o(s_wlast_o),
    .s_wvalid_o(s_wvalid_o), .s_wready_i(s_wready_i), .s_bid_i(s_bid_i),
    .s_bresp_i(s_bresp_i), .s_bvalid_i(s_bvalid_i), .s_bready_o(s_bready_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .frame_drop_o(frame_drop_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  // FIFO model: first-word-fall-through counter, advanced on each pop.
  assign fifo_data_i = fifo_head;
  always @(posedge clk) begin
    if (fifo_rd_o) fifo_head <= fifo_head + 32'd1;
  end

  // AXI slave responder, driven just after each rising edge.
  initial begin
    int aw_wait;
    aw_wait = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_i) begin
        s_bvalid_i = 1'b0;
        s_awready_i = 1'b0;
        s_wready_i = 1'b1;
        aw_wait = 0;
      end else begin
        s_wready_i = wready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (s_awvalid_o) begin
          s_awready_i = (aw_wait >= aw_delay);
          aw_wait++;
        end else begin
          s_awready_i = 1'b0;
          aw_wait = 0;
        end
        if (s_bvalid_i) begin
          s_bvalid_i = 1'b0;
        end else if (s_bready_o) begin
          s_bvalid_i = 1'b1;
          s_bresp_i = (b_count == bad_b_at) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // Monitor: records handshakes seen at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (s_awvalid_o) begin
          aw_valid_cycles++;
          if (aw_hold_valid && (s_awaddr_o !== aw_hold_addr)) stab_err++;
          aw_hold_valid = !s_awready_i;
          aw_hold_addr = s_awaddr_o;
          if (s_awready_i) begin
            aw_q.push_back(s_awaddr_o);
            if (s_awlen_o !== 8'd15 || s_awsize_o !== 3'd2 || s_awid_o !== 5'd0) attr_err++;
          end
        end else begin
          aw_hold_valid = 1'b0;
        end
        if (fifo_rd_o !== (s_wvalid_o & s_wready_i)) rd_err++;
        if (s_wvalid_o && s_wready_i) begin
          if (s_wdata_o !== w_exp) wdata_err++;
          if (s_wlast_o) wlast_q.push_back(beats);
          w_exp = w_exp + 32'd1;
          beats++;
        end
        if (s_bvalid_i && s_bready_o) b_count++;
        if (frame_done_o) done_cnt++;
        if (frame_drop_o) drop_cnt++;
      end
    end
  end

  task automatic reset_stats();
    @(posedge clk);
    #1;
    aw_q.delete();
    wlast_q.delete();
    beats = 0; b_count = 0; done_cnt = 0; drop_cnt = 0;
    aw_valid_cycles = 0; stab_err = 0; attr_err = 0; rd_err = 0; wdata_err = 0;
    aw_hold_valid = 1'b0;
    w_exp = fifo_head;
  endtask

  task automatic start_frame(input logic [31:0] base, input logic [19:0] words);
    @(posedge clk);
    #1;
    base_addr_i = base;
    frame_words_i = words;
    frame_start_i = 1'b1;
    @(posedge clk);
    #1;
    frame_start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_awvalid_o, s_wvalid_o, s_wlast_o, fifo_rd_o, s_bready_o, busy_o,
         frame_done_o, frame_drop_o, err_o} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000000",
               {s_awvalid_o, s_wvalid_o, s_wlast_o, fifo_rd_o, s_bready_o, busy_o,
                frame_done_o, frame_drop_o, err_o});
    end
    checks++;
    if (s_awlen_o !== 8'd15 || s_awsize_o !== 3'd2 || s_awid_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_consts: got len=%0d size=%0d id=%0d expected 15/2/0",
               s_awlen_o, s_awsize_o, s_awid_o);
    end
    // A start pulse while disabled is silently ignored.
    reset_stats();
    en_i = 1'b0;
    start_frame(32'h0000_0000, 20'd16);
    repeat (3) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || drop_cnt != 0 || aw_q.size() != 0) begin
      errors++;
      $display("FAIL disabled_start: got busy=%b drops=%0d aw=%0d expected 0/0/0",
               busy_o, drop_cnt, aw_q.size());
    end
    en_i = 1'b1;
  endtask

  task automatic test_basic_frame();
    bit ok;
    logic [31:0] exp_a;
    reset_stats();
    start_frame(32'h8000_0000, 20'd64);
    wait_done(600, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || done_cnt != 1) begin
      errors++;
      $display("FAIL basic_done: got ok=%b pulses=%0d expected 1/1", ok, done_cnt);
    end
    checks++;
    if (aw_q.size() != 4) begin
      errors++;
      $display("FAIL basic_aw_count: got %0d expected 4", aw_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      exp_a = 32'h8000_0000 + 32'(i) * 32'h40;
      checks++;
      if (i >= aw_q.size() || aw_q[i] !== exp_a) begin
        errors++;
        $display("FAIL basic_awaddr[%0d]: got %h expected %h", i,
                 (i < aw_q.size()) ? aw_q[i] : 32'hxxxx_xxxx, exp_a);
      end
      checks++;
      if (i >= wlast_q.size() || wlast_q[i] != 16 * i + 15) begin
        errors++;
        $display("FAIL basic_wlast[%0d]: got %0d expected %0d", i,
                 (i < wlast_q.size()) ? wlast_q[i] : -1, 16 * i + 15);
      end
    end
    checks++;
    if (beats != 64 || rd_err != 0 || wdata_err != 0 || attr_err != 0) begin
      errors++;
      $display("FAIL basic_beats: got beats=%0d rd_err=%0d wdata_err=%0d attr_err=%0d expected 64/0/0/0",
               beats, rd_err, wdata_err, attr_err);
    end
    checks++;
    if (busy_o !== 1'b0 || wlast_q.size() != 4) begin
      errors++;
      $display("FAIL basic_end: got busy=%b wlasts=%0d expected 0/4", busy_o, wlast_q.size());
    end
  endtask

  task automatic test_threshold();
    bit ok;
    int awseen;
    fifo_cnt_i = 6'd15;
    reset_stats();
    start_frame(32'h0000_1000, 20'd16);
    awseen = 0;
    repeat (50) begin
      @(negedge clk);
      if (s_awvalid_o) awseen++;
    end
    checks++;
    if (awseen != 0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL thr_hold: got aw_cycles=%0d busy=%b expected 0/1", awseen, busy_o);
    end
    @(posedge clk);
    #1;
    fifo_cnt_i = 6'd16;
    @(negedge clk);
    checks++;
    if (s_awvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL thr_same_cycle: got awvalid=%b expected 0", s_awvalid_o);
    end
    @(negedge clk);
    checks++;
    if (s_awvalid_o !== 1'b1) begin
      errors++;
      $display("FAIL thr_next_cycle: got awvalid=%b expected 1", s_awvalid_o);
    end
    wait_done(200, ok);
    checks++;
    if (!ok || aw_q.size() != 1 || aw_q[0] !== 32'h0000_1000 || beats != 16) begin
      errors++;
      $display("FAIL thr_frame: got done=%b aw=%0d beats=%0d expected 1/1/16 at 00001000",
               ok, aw_q.size(), beats);
    end
    fifo_cnt_i = 6'd32;
  endtask

  task automatic test_stall();
    bit ok;
    aw_delay = 5;
    wready_rand = 1'b1;
    reset_stats();
    start_frame(32'h2000_0000, 20'd32);
    wait_done(1000, ok);
    checks++;
    if (!ok || stab_err != 0 || aw_valid_cycles != 12) begin
      errors++;
      $display("FAIL stall_aw: got done=%b unstable=%0d aw_cycles=%0d expected 1/0/12",
               ok, stab_err, aw_valid_cycles);
    end
    checks++;
    if (aw_q.size() != 2 || aw_q[0] !== 32'h2000_0000 || aw_q[1] !== 32'h2000_0040) begin
      errors++;
      $display("FAIL stall_addr: got n=%0d expected 2 at 20000000/20000040", aw_q.size());
    end
    checks++;
    if (beats != 32 || wdata_err != 0 || rd_err != 0) begin
      errors++;
      $display("FAIL stall_data: got beats=%0d wdata_err=%0d rd_err=%0d expected 32/0/0",
               beats, wdata_err, rd_err);
    end
    checks++;
    if (wlast_q.size() != 2 || wlast_q[0] != 15 || wlast_q[1] != 31) begin
      errors++;
      $display("FAIL stall_wlast: got n=%0d expected beats 15/31", wlast_q.size());
    end
    aw_delay = 0;
    wready_rand = 1'b0;
  endtask

  task automatic test_error();
    bit ok;
    reset_stats();
    bad_b_at = 1;
    start_frame(32'h3000_0000, 20'd64);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_initial: got %b expected 0", err_o);
    end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (b_count >= 2) break;
    end
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got %b expected 1", err_o);
    end
    wait_done(400, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || err_o !== 1'b1 || aw_q.size() != 4) begin
      errors++;
      $display("FAIL err_sticky: got done=%b err=%b aw=%0d expected 1/1/4", ok, err_o, aw_q.size());
    end
    bad_b_at = -1;
    @(posedge clk);
    #1;
    err_clr_i = 1'b1;
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_before_clr: got %b expected 1", err_o);
    end
    @(posedge clk);
    #1;
    err_clr_i = 1'b0;
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared: got %b expected 0", err_o);
    end
  endtask

  task automatic test_drop_and_stop();
    reset_stats();
    start_frame(32'h4000_0000, 20'd64);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (aw_q.size() >= 1) break;
    end
    @(posedge clk);
    #1;
    base_addr_i = 32'h5000_0000;
    frame_words_i = 20'd16;
    frame_start_i = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_drop_o !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse: got %b expected 1", frame_drop_o);
    end
    @(posedge clk);
    #1;
    frame_start_i = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_drop_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_clear: got %b expected 0", frame_drop_o);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (aw_q.size() >= 2) break;
    end
    @(posedge clk);
    #1;
    en_i = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (aw_q.size() != 2 || aw_q[0] !== 32'h4000_0000 || aw_q[1] !== 32'h4000_0040) begin
      errors++;
      $display("FAIL stop_addr: got n=%0d expected 2 at 40000000/40000040", aw_q.size());
    end
    checks++;
    if (beats != 32 || b_count != 2) begin
      errors++;
      $display("FAIL stop_burst_done: got beats=%0d b=%0d expected 32/2", beats, b_count);
    end
    checks++;
    if (busy_o !== 1'b0 || done_cnt != 0 || drop_cnt != 1) begin
      errors++;
      $display("FAIL stop_state: got busy=%b done=%0d drops=%0d expected 0/0/1",
               busy_o, done_cnt, drop_cnt);
    end
    en_i = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    reset_stats();
    bad_b_at = 0;
    start_frame(32'h6000_0000, 20'd64);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (beats >= 20) break;
    end
    checks++;
    if (err_o !== 1'b1 || s_wvalid_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got err=%b wvalid=%b expected 1/1", err_o, s_wvalid_o);
    end
    bad_b_at = -1;
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_awvalid_o, s_wvalid_o, fifo_rd_o, s_bready_o, busy_o, err_o, frame_done_o} !== 7'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b expected 0000000",
               {s_awvalid_o, s_wvalid_o, fifo_rd_o, s_bready_o, busy_o, err_o, frame_done_o});
    end
    reset_stats();
    start_frame(32'h6000_0000, 20'd16);
    wait_done(300, ok);
    checks++;
    if (!ok || aw_q.size() != 1 || aw_q[0] !== 32'h6000_0000 || beats != 16 || wdata_err != 0) begin
      errors++;
      $display("FAIL rstmid_restart: got done=%b aw=%0d beats=%0d wdata_err=%0d expected 1/1/16/0",
               ok, aw_q.size(), beats, wdata_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_threshold();
    test_stall();
    test_error();
    test_drop_and_stop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
